// File: rtl/scalar_sub_mat_sched.sv
`default_nettype none
// ============================================================================
// Module   : scalar_sub_mat_sched
// Purpose  : Streams a SIZE_A x SIZE_B matrix through one shared pipelined
//            fp_sub, computing mat_out = mat - scale in row-major order.
// Options  : SCALAR_SUB_ABORT_EN adds an abort input that cancels a run.
// Revision : 1.0 - initial release
// ============================================================================
module scalar_sub_mat_sched #(
    parameter int SIZE_A  = 8,
    parameter int SIZE_B  = 8,
    parameter int SUB_LAT = 7
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
`ifdef SCALAR_SUB_ABORT_EN
    input  logic                               abort,
`endif
    input  logic [63:0]                        scale,
    input  logic [SIZE_A-1:0][SIZE_B-1:0][63:0] mat,
    output logic [63:0]                        sub_a,
    output logic [63:0]                        sub_b,
    input  logic [63:0]                        sub_q,
    output logic                               busy,
    output logic                               done,
    output logic [SIZE_A-1:0][SIZE_B-1:0][63:0] mat_out
);

    localparam int              c_N    = SIZE_A * SIZE_B;
    localparam int              c_IW   = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(c_N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_IW-1:0]        r_k;
    logic [63:0]            r_scale;
    logic [SUB_LAT-1:0]     r_vld;
    logic [c_IW-1:0]        r_idx [SUB_LAT];
    logic [c_N-1:0][63:0]   r_res;
    logic [c_N-1:0][63:0]   w_src;
    logic                   w_abort;
    logic                   w_push;

    // Packed row-major layout lets element k be addressed directly, no divide.
    assign w_src   = mat;
    assign mat_out = r_res;
    assign w_push  = (r_state == S_ISSUE);

`ifdef SCALAR_SUB_ABORT_EN
    assign w_abort = abort && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_scale <= '0;
            sub_a   <= '0;
            sub_b   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (w_abort) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_scale <= scale;
                        r_k     <= '0;
                        busy    <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    sub_a <= w_src[r_k];
                    sub_b <= r_scale;
                    if (r_k == c_LAST) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Empty delay line means the final capture happened last edge.
                    if (r_vld == '0) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int s = 0; s < SUB_LAT; s++) begin
                r_idx[s] <= '0;
            end
        end else if (w_abort) begin
            r_vld <= '0;
        end else begin
            for (int s = SUB_LAT - 1; s > 0; s--) begin
                r_vld[s] <= r_vld[s-1];
                r_idx[s] <= r_idx[s-1];
            end
            r_vld[0] <= w_push;
            r_idx[0] <= r_k;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res <= '0;
        end else if (r_vld[SUB_LAT-1] && !w_abort) begin
            r_res[r_idx[SUB_LAT-1]] <= sub_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scalar_sub_mat_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_scalar_sub_mat_sched
// Purpose  : Vector table, timing corner sequences and randomized runs of
//            scalar_sub_mat_sched against a real-arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scalar_sub_mat_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic logic [63:0] fsub(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) - $bitstoreal(b));
    endfunction

    // ---------------- instance A: 2x2, latency 3 ----------------
    logic                    start_a = 1'b0;
    logic                    abort_a = 1'b0;
    logic [63:0]             scale_a = '0;
    logic [1:0][1:0][63:0]   mat_a   = '0;
    logic [63:0]             sa_a, sb_a, sq_a;
    logic                    busy_a, done_a;
    logic [1:0][1:0][63:0]   out_a;
    logic [63:0]             pa [2];

    scalar_sub_mat_sched #(.SIZE_A(2), .SIZE_B(2), .SUB_LAT(3)) u_a (
        .clk(clk), .rst(rst), .start(start_a),
`ifdef SCALAR_SUB_ABORT_EN
        .abort(abort_a),
`endif
        .scale(scale_a), .mat(mat_a), .sub_a(sa_a), .sub_b(sb_a), .sub_q(sq_a),
        .busy(busy_a), .done(done_a), .mat_out(out_a)
    );
    always @(posedge clk) begin
        pa[0] <= fsub(sa_a, sb_a);
        pa[1] <= pa[0];
    end
    assign sq_a = pa[1];

    // ---------------- instances B/C: 8x8, latency 1 and 7 ----------------
    logic                    start8  = 1'b0;
    logic                    abort_n = 1'b0;
    logic [63:0]             scale8  = '0;
    logic [7:0][7:0][63:0]   mat8    = '0;
    logic [63:0]             sa_b, sb_b, sq_b, sa_c, sb_c, sq_c;
    logic                    busy_b, done_b, busy_c, done_c;
    logic [7:0][7:0][63:0]   out_b, out_c;
    logic [63:0]             pc [6];

    scalar_sub_mat_sched #(.SIZE_A(8), .SIZE_B(8), .SUB_LAT(1)) u_b (
        .clk(clk), .rst(rst), .start(start8),
`ifdef SCALAR_SUB_ABORT_EN
        .abort(abort_n),
`endif
        .scale(scale8), .mat(mat8), .sub_a(sa_b), .sub_b(sb_b), .sub_q(sq_b),
        .busy(busy_b), .done(done_b), .mat_out(out_b)
    );
    assign sq_b = fsub(sa_b, sb_b);

    scalar_sub_mat_sched #(.SIZE_A(8), .SIZE_B(8), .SUB_LAT(7)) u_c (
        .clk(clk), .rst(rst), .start(start8),
`ifdef SCALAR_SUB_ABORT_EN
        .abort(abort_n),
`endif
        .scale(scale8), .mat(mat8), .sub_a(sa_c), .sub_b(sb_c), .sub_q(sq_c),
        .busy(busy_c), .done(done_c), .mat_out(out_c)
    );
    always @(posedge clk) begin
        pc[0] <= fsub(sa_c, sb_c);
        for (int s = 1; s < 6; s++) pc[s] <= pc[s-1];
    end
    assign sq_c = pc[5];

    // ---------------- instance D: 1x1, latency 3 ----------------
    logic                    start1 = 1'b0;
    logic [63:0]             scale1 = '0;
    logic [0:0][0:0][63:0]   mat1   = '0;
    logic [63:0]             sa_d, sb_d, sq_d;
    logic                    busy_d, done_d;
    logic [0:0][0:0][63:0]   out_d;
    logic [63:0]             pd [2];

    scalar_sub_mat_sched #(.SIZE_A(1), .SIZE_B(1), .SUB_LAT(3)) u_d (
        .clk(clk), .rst(rst), .start(start1),
`ifdef SCALAR_SUB_ABORT_EN
        .abort(abort_n),
`endif
        .scale(scale1), .mat(mat1), .sub_a(sa_d), .sub_b(sb_d), .sub_q(sq_d),
        .busy(busy_d), .done(done_d), .mat_out(out_d)
    );
    always @(posedge clk) begin
        pd[0] <= fsub(sa_d, sb_d);
        pd[1] <= pd[0];
    end
    assign sq_d = pd[1];

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0][63:0] r4(input real a, input real b, input real c, input real d);
        return {$realtobits(d), $realtobits(c), $realtobits(b), $realtobits(a)};
    endfunction

    function automatic logic [63:0] rnd_val();
        return $realtobits(real'(int'($urandom_range(0, 4000)) - 2000) / 8.0);
    endfunction

    typedef struct {
        logic [3:0][63:0] m;
        logic [63:0]      sc;
        logic [3:0][63:0] e;
    } vec_t;
    vec_t tbl [4];

    // Start edge is E0; the count c is the edge number after which done is seen.
    task automatic run_a(input int restart_e, input int rst_e, input int abort_e,
                         output int done_cyc, output int ndone, output bit busy_ok);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a  = 1'b0;
        done_cyc = -1;
        ndone    = 0;
        busy_ok  = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            if (c == restart_e) begin
                start_a = 1'b1;
                scale_a = $realtobits(100.0);
            end
            if (c == abort_e) abort_a = 1'b1;
            if (c == rst_e) begin
                rst = 1'b1;
                #1;
                chk("rst_mid_busy", 64'(busy_a), 64'd0);
                chk("rst_mid_done", 64'(done_a), 64'd0);
                chk("rst_mid_matout_nonzero", 64'(|out_a), 64'd0);
            end
            @(posedge clk);
            @(negedge clk);
            start_a = 1'b0;
            abort_a = 1'b0;
            rst     = 1'b0;
            if (done_a) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc < 0 && busy_a !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic load_a(input vec_t v);
        for (int k = 0; k < 4; k++) mat_a[k/2][k%2] = v.m[k];
        scale_a = v.sc;
    endtask

    task automatic check_a(input string nm, input logic [3:0][63:0] e);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_out%0d", nm, k), out_a[k/2][k%2], e[k]);
    endtask

    task automatic run8(output int dc_b, output int dc_c);
        @(negedge clk);
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        dc_b = -1;
        dc_c = -1;
        for (int c = 1; c <= 90; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_b && dc_b < 0) dc_b = c;
            if (done_c && dc_c < 0) dc_c = c;
        end
    endtask

    initial begin
        int  dc, nd, dc2;
        bit  bok;
        vec_t rv;
        logic [7:0][7:0][63:0] exp8;

        #1;
        chk("reset_busy", 64'(busy_a), 64'd0);
        chk("reset_done", 64'(done_a), 64'd0);
        chk("reset_sub_a", sa_a, 64'd0);
        chk("reset_sub_b", sb_a, 64'd0);
        chk("reset_matout_nonzero", 64'(|out_a), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        tbl[0] = '{m: r4(1.0, 2.0, 3.0, 4.0),      sc: $realtobits(0.5),
                   e: r4(0.5, 1.5, 2.5, 3.5)};
        tbl[1] = '{m: r4(10.0, -3.0, 0.0, 7.25),   sc: $realtobits(2.0),
                   e: r4(8.0, -5.0, -2.0, 5.25)};
        tbl[2] = '{m: r4(0.0, 1.0, -1.0, 0.5),     sc: $realtobits(-1.5),
                   e: r4(1.5, 2.5, 0.5, 2.0)};
        tbl[3] = '{m: r4(1000.0, 2.5, -0.5, 100.0), sc: $realtobits(0.25),
                   e: r4(999.75, 2.25, -0.75, 99.75)};

        for (int v = 0; v < 4; v++) begin
            load_a(tbl[v]);
            run_a(0, 0, 0, dc, nd, bok);
            check_a($sformatf("vec%0d", v), tbl[v].e);
            chk($sformatf("vec%0d_done_cycle", v), 64'(dc), 64'd8);
            chk($sformatf("vec%0d_done_pulses", v), 64'(nd), 64'd1);
            chk($sformatf("vec%0d_busy_held", v), 64'(bok), 64'd1);
        end

        // Second start mid-ISSUE carries scale 100.0 and must be ignored.
        load_a(tbl[0]);
        run_a(2, 0, 0, dc, nd, bok);
        check_a("restart", tbl[0].e);
        chk("restart_done_cycle", 64'(dc), 64'd8);
        chk("restart_done_pulses", 64'(nd), 64'd1);

        // Reset lands during DRAIN (after edge 5).
        load_a(tbl[1]);
        run_a(0, 6, 0, dc, nd, bok);
        chk("rst_mid_no_done", 64'(nd), 64'd0);

`ifdef SCALAR_SUB_ABORT_EN
        load_a(tbl[1]);
        run_a(0, 0, 4, dc, nd, bok);
        chk("abort_no_done", 64'(nd), 64'd0);
        chk("abort_busy", 64'(busy_a), 64'd0);
        check_a("abort", '0);
`endif

        load_a(tbl[2]);
        run_a(0, 0, 0, dc, nd, bok);
        check_a("after_rst", tbl[2].e);
        chk("after_rst_done_cycle", 64'(dc), 64'd8);

        for (int r = 0; r < 6; r++) begin
            rv.sc = rnd_val();
            for (int k = 0; k < 4; k++) begin
                rv.m[k] = rnd_val();
                rv.e[k] = $realtobits($bitstoreal(rv.m[k]) - $bitstoreal(rv.sc));
            end
            load_a(rv);
            run_a(0, 0, 0, dc, nd, bok);
            check_a($sformatf("rand%0d", r), rv.e);
            chk($sformatf("rand%0d_done_cycle", r), 64'(dc), 64'd8);
        end

        // Latency sweep on 8x8: mat = k+1.0, scale = 1.0 gives 8i+j.
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                mat8[i][j] = $realtobits(real'(8*i + j) + 1.0);
        scale8 = $realtobits(1.0);
        run8(dc, dc2);
        chk("lat1_done_cycle", 64'(dc), 64'd66);
        chk("lat7_done_cycle", 64'(dc2), 64'd72);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                chk($sformatf("lat1_out_%0d_%0d", i, j), out_b[i][j], $realtobits(real'(8*i + j)));
                chk($sformatf("lat7_out_%0d_%0d", i, j), out_c[i][j], $realtobits(real'(8*i + j)));
            end

        scale8 = rnd_val();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                mat8[i][j] = rnd_val();
                exp8[i][j] = $realtobits($bitstoreal(mat8[i][j]) - $bitstoreal(scale8));
            end
        run8(dc, dc2);
        chk("rand8_lat1_done_cycle", 64'(dc), 64'd66);
        chk("rand8_lat7_done_cycle", 64'(dc2), 64'd72);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                chk($sformatf("rand8_lat1_%0d_%0d", i, j), out_b[i][j], exp8[i][j]);
                chk($sformatf("rand8_lat7_%0d_%0d", i, j), out_c[i][j], exp8[i][j]);
            end

        // Single-element matrix.
        mat1[0][0] = $realtobits(3.0);
        scale1     = $realtobits(-2.0);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        dc = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_d && dc < 0) dc = c;
        end
        chk("n1_done_cycle", 64'(dc), 64'd5);
        chk("n1_out", out_d[0][0], $realtobits(5.0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scalar_sub_mat_sched.md
Name: scalar_sub_mat_sched

Overview:
Sequencer that streams a SIZE_A x SIZE_B matrix through one shared, pipelined fp_sub (double precision) instead of one subtractor per element. It computes mat_out[i][j] = mat[i][j] - scale. It issues one element per cycle in row-major order, tracks in-flight results with a valid/index delay line matched to the subtractor latency, and writes the results back into a registered output matrix. It sits between the whitening/centering control logic and a single fp_sub instance, trading throughput for area.

Parameters:
SIZE_A, 8, number of matrix rows
SIZE_B, 8, number of matrix columns
SUB_LAT, 7, fixed pipeline latency of the attached fp_sub in cycles (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to process mat; honoured only in IDLE
scale  input  64 (double)  scalar subtrahend; latched when start is accepted
mat  input  SIZE_A x SIZE_B x 64 (double)  source matrix; caller holds it stable while busy=1
sub_a  output  64 (double)  minuend to the shared fp_sub (drive to its .a)
sub_b  output  64 (double)  subtrahend to the shared fp_sub (drive to its .b)
sub_q  input  64 (double)  result from the shared fp_sub (.q)
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when every element of mat_out is valid
mat_out  output  SIZE_A x SIZE_B x 64 (double)  registered result matrix

Behaviour:
- Reset (async, rst=1): state=IDLE; sub_a=sub_b=0; busy=0; done=0; all mat_out entries=0; delay line valids cleared; issue index=0.
- N = SIZE_A*SIZE_B. Index width = max(1,$clog2(N)). Element k maps to i=k/SIZE_B, j=k%SIZE_B.
- States:
  - IDLE: done=0. If start=1, latch scale, set issue index=0, go to ISSUE. start seen outside IDLE is ignored and not queued.
  - ISSUE: each cycle, register sub_a<=mat[i][j] and sub_b<=scale_latched for index k. Push (valid=1, k) into the SUB_LAT-deep delay line, then k++. After k=N-1 is issued, go to DRAIN.
  - DRAIN: issue nothing and push valid=0. When the delay-line tail valid goes low with no valid entries remaining, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Capture: when the delay-line tail is valid, mat_out[i][j] <= sub_q for the tail index. The tail lines up with the element presented on sub_a/sub_b exactly SUB_LAT cycles earlier.
- Timing: start accepted at edge E0. Element k is on sub_a/sub_b in cycles E(1+k)..E(2+k). Its result is captured at edge E(1+k+SUB_LAT). done is high in the cycle after the last capture. Start-to-done = N+SUB_LAT+1 cycles.
- mat_out entries not yet rewritten keep their previous values. A new run overwrites every entry.
- sub_a/sub_b hold their last values outside ISSUE.
- back-to-back: start asserted in the DONE cycle is ignored. start in the following IDLE cycle is accepted.
- N=1 is legal: one ISSUE cycle, then DRAIN.
- rst mid-run: immediate return to reset values. No done is produced.

Optional Feature:
SCALAR_SUB_ABORT_EN:
- Defined: adds input port abort (1 bit). abort=1 in ISSUE or DRAIN sends the block to IDLE at the next edge, clears every delay-line valid, and sets busy=0 with no done pulse. mat_out keeps whatever was captured before the abort edge. abort in IDLE or DONE has no effect. If abort and the final capture happen at the same edge, abort wins and done is suppressed.
- Undefined: no abort port, and none of this logic is present.

Test Plan:
- 2x2, SUB_LAT=3, bench fp_sub model. mat={1.0,2.0,3.0,4.0}, scale=0.5, start pulse -> mat_out={0.5,1.5,2.5,3.5}; done exactly 8 cycles after the start edge; busy high throughout.
- Latency sweep, SUB_LAT in {1,7}, 8x8 matrix of k+1.0 with scale=1.0 -> mat_out[i][j]=8i+j; done at cycle 65+SUB_LAT.
- Start while busy: second start with scale=100.0 mid-ISSUE -> ignored; results still use the first scale; exactly one done pulse.
- Reset mid-DRAIN: rst pulse -> busy=0, done=0, mat_out all zero. A fresh start afterwards completes normally.
- Abort (SCALAR_SUB_ABORT_EN defined), 2x2, SUB_LAT=3: abort one cycle after element 2 is issued -> no done; elements 0-1 not captured; mat_out unchanged from reset (0.0).
- 1x1, scale=-2.0, mat=3.0 -> mat_out=5.0; done 5 cycles after start (SUB_LAT=3).
